// File: rtl/fft_twiddle_pkg.sv
// Shared helpers for the twiddle generator: quarter-wave cosine table builder,
// (stage, index) -> exponent mapping and derived-width helpers.
package fft_twiddle_pkg;

  typedef enum logic {
    QUAD_LOW  = 1'b0,
    QUAD_HIGH = 1'b1
  } quad_e;

  localparam longint FX_ONE = 64'sd1 <<< 30;
  localparam longint PI_FX  = 64'sd3373259426;

  function automatic int unsigned calc_log2n(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned calc_sw(input int unsigned n);
    return $clog2($clog2(n));
  endfunction

  // Taylor series in Q30 integer arithmetic keeps elaboration free of real math;
  // the result is rounded half away from zero to frac_w fraction bits.
  function automatic int cos_q(input int unsigned i, input int unsigned q,
                               input int unsigned frac_w);
    longint x, x2, term, sum, half;
    int     res;
    x    = (PI_FX * longint'(i)) / longint'(2 * q);
    x2   = (x * x) >>> 30;
    term = FX_ONE;
    sum  = FX_ONE;
    for (int unsigned n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    half = 64'sd1 <<< (29 - frac_w);
    if (sum >= 0) res = int'((sum + half) >>> (30 - frac_w));
    else          res = -int'((-sum + half) >>> (30 - frac_w));
    return res;
  endfunction

  function automatic int unsigned twiddle_k(input int unsigned s, input int unsigned j,
                                            input int unsigned log2n);
    int unsigned se;
    se = (s >= log2n) ? log2n - 1 : s;
    return (j & ((32'd1 << se) - 32'd1)) << (log2n - 1 - se);
  endfunction

endpackage

// File: rtl/fft_twiddle_gen_qrom.sv
// Quarter-wave cosine ROM (Q+1 entries), two registered read ports sharing one
// clock enable; read data carries no reset.
module twiddle_qrom
  import fft_twiddle_pkg::*;
#(
  parameter int unsigned Q      = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr_a,
  input  logic [AW-1:0]     addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  logic [DATA_W-1:0] rom [Q+1];

  for (genvar g = 0; g <= int'(Q); g++) begin : g_entry
    assign rom[g] = DATA_W'(cos_q(g, Q, FRAC_W));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Radix-2 DIT twiddle generator: (stage, index) -> W_N^k in signed fixed point,
// 3-stage stallable pipe. Define TWIDDLE_INVERSE_EN to add the inv (conjugate) input.
module fft_twiddle_gen
  import fft_twiddle_pkg::*;
#(
  parameter  int unsigned N_POINTS = 32,
  parameter  int unsigned DATA_W   = 16,
  parameter  int unsigned FRAC_W   = 8,
  localparam int unsigned LOG2N    = calc_log2n(N_POINTS),
  localparam int unsigned SW       = calc_sw(N_POINTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SW-1:0]     in_stage,
  input  logic [LOG2N-2:0]  in_idx,
`ifdef TWIDDLE_INVERSE_EN
  input  logic              inv,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-2:0]  out_k
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned Q  = N_POINTS / 4;

  logic          en;
  logic          inv_in;
  logic [KW-1:0] k_in, addr_re_in, addr_im_in;
  quad_e         quad_in;

  logic          v1, v2;
  logic [KW-1:0] k1, k2, addr_re1, addr_im1;
  quad_e         quad1, quad2;
  logic          inv1, inv2;
  logic [DATA_W-1:0] rom_re, rom_im;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

`ifdef TWIDDLE_INVERSE_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  // Second quadrant mirrors the first: re uses T[Q-m], im uses T[m], m = k-Q.
  always_comb begin
    k_in = KW'(twiddle_k(32'(in_stage), 32'(in_idx), LOG2N));
    if (k_in > KW'(Q)) begin
      quad_in    = QUAD_HIGH;
      addr_re_in = KW'(Q) - (k_in - KW'(Q));
      addr_im_in = k_in - KW'(Q);
    end else begin
      quad_in    = QUAD_LOW;
      addr_re_in = k_in;
      addr_im_in = KW'(Q) - k_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_k     <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      out_k     <= k2;
      out_re    <= (quad2 == QUAD_HIGH) ? -rom_re : rom_re;
      out_im    <= inv2 ? rom_im : -rom_im;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      k1       <= k_in;
      addr_re1 <= addr_re_in;
      addr_im1 <= addr_im_in;
      quad1    <= quad_in;
      inv1     <= inv_in;
      k2       <= k1;
      quad2    <= quad1;
      inv2     <= inv1;
    end
  end

  twiddle_qrom #(
    .Q      (Q),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .AW     (KW)
  ) u_qrom (
    .clk    (clk),
    .en     (en),
    .addr_a (addr_re1),
    .addr_b (addr_im1),
    .data_a (rom_re),
    .data_b (rom_im)
  );

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Self-checking bench for fft_twiddle_gen at N=32, DATA_W=16, FRAC_W=8:
// real-valued twiddle model, scoreboard compare process and directed literal vectors.
module tb_fft_twiddle_gen;

  localparam int  N     = 32;
  localparam int  DW    = 16;
  localparam int  FW    = 8;
  localparam int  LOG2N = 5;
  localparam int  SW    = 3;
  localparam int  KW    = 4;
  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = 256.0;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [KW-1:0] k;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_stage = '0;
  logic [KW-1:0] in_idx = '0;
  logic          inv = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_re, out_im;
  logic [KW-1:0] out_k;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  exp_t held;
  bit   stalled = 1'b0;

  always #5 clk = ~clk;

  fft_twiddle_gen #(
    .N_POINTS (N),
    .DATA_W   (DW),
    .FRAC_W   (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_stage  (in_stage),
    .in_idx    (in_idx),
`ifdef TWIDDLE_INVERSE_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_k     (out_k)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

  function automatic exp_t model(input int s, input int j, input bit iv);
    int   se, kk, re, im;
    real  ang;
    exp_t e;
    se  = (s >= LOG2N) ? LOG2N - 1 : s;
    kk  = (j % (1 << se)) * (1 << (LOG2N - 1 - se));
    ang = 2.0 * PI * kk / N;
    re  = rnd($cos(ang) * SCALE);
    im  = -rnd($sin(ang) * SCALE);
    if (iv) im = -im;
    e.re = DW'(re);
    e.im = DW'(im);
    e.k  = KW'(kk);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stalled) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", {out_re, out_im, out_k}, held);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_output", out_valid, 0);
        else check("out_vs_model", {out_re, out_im, out_k}, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(model(int'(in_stage), int'(in_idx), inv));
      stalled = out_valid && !out_ready;
      held    = {out_re, out_im, out_k};
    end
  end

  task automatic send_one(input string name, input int s, input int j, input bit iv,
                          input logic [DW-1:0] er, input logic [DW-1:0] ei, input int ek);
    int lat;
    in_valid  = 1'b1;
    in_stage  = SW'(s);
    in_idx    = KW'(j);
    inv       = iv;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inv      = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_re"}, out_re, er);
    check({name, "_im"}, out_im, ei);
    check({name, "_k"}, out_k, ek);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   first, last, cnt, sent;

    e = model(4, 9, 1'b0);
    check("model_k9", e, {16'hFFCE, 16'hFF05, 4'd9});
    e = model(4, 1, 1'b0);
    check("model_k1", e, {16'h00FB, 16'hFFCE, 4'd1});
    e = model(2, 6, 1'b0);
    check("model_k8", e, {16'h0000, 16'hFF00, 4'd8});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_re", out_re, 0);
    check("reset_out_im", out_im, 0);
    check("reset_out_k", out_k, 0);
    check("reset_in_ready", in_ready, 1);

    send_one("s0j13", 0, 13, 1'b0, 16'h0100, 16'h0000, 0);
    send_one("s2j6",  2, 6,  1'b0, 16'h0000, 16'hFF00, 8);
    send_one("s4j1",  4, 1,  1'b0, 16'h00FB, 16'hFFCE, 1);
    send_one("s4j9",  4, 9,  1'b0, 16'hFFCE, 16'hFF05, 9);
    send_one("s4j12", 4, 12, 1'b0, 16'hFF4B, 16'hFF4B, 12);
    send_one("s4j4",  4, 4,  1'b0, 16'h00B5, 16'hFF4B, 4);
    send_one("s7j3",  7, 3,  1'b0, 16'h00D5, 16'hFF72, 3);
`ifdef TWIDDLE_INVERSE_EN
    send_one("inv_s2j6", 2, 6, 1'b1, 16'h0000, 16'h0100, 8);
`endif

    // back-to-back stream, never stalled
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 22; c++) begin
      in_valid = (c < 16);
      in_stage = 3'd4;
      in_idx   = KW'(c);
      @(posedge clk); #1;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    check("stream_count", cnt, 16);
    check("stream_contiguous", last - first, 15);
    check("stream_first_cycle", first, 2);

    // stream with a 5-cycle downstream stall in the middle
    sent = 0;
    for (int c = 0; c < 32; c++) begin
      in_valid  = (sent < 16);
      in_stage  = 3'd4;
      in_idx    = KW'(15 - sent);
      out_ready = !(c >= 6 && c < 11);
      #1;
      if (c >= 6 && c < 11) check("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("stall_no_loss", sb.size(), 0);

    // reset with two requests in flight
    in_valid = 1'b1; in_stage = 3'd4; in_idx = 4'd5;
    @(posedge clk); #1;
    in_idx = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_re", out_re, 0);
    check("midrst_out_im", out_im, 0);
    check("midrst_out_k", out_k, 0);
    repeat (4) @(posedge clk);
    #1 check("midrst_no_partial", out_valid, 0);
    send_one("post_rst_s4j9", 4, 9, 1'b0, 16'hFFCE, 16'hFF05, 9);

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_stage  = SW'($urandom_range(0, 7));
      in_idx    = KW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef TWIDDLE_INVERSE_EN
      inv = 1'($urandom_range(0, 1));
`endif
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    inv       = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("random_drain_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
